// File: rtl/match_window_counter.sv
// match_window_counter: counts detector hits over fixed windows of counted
// bit-times and hands each window count out through a one-entry report buffer.
module match_window_counter #(
  parameter int WIN_LEN = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          det,
  output logic          rpt_valid,
  input  logic          rpt_ready,
  output logic [CW-1:0] rpt_count,
  output logic          rpt_partial,
  output logic [15:0]   total_hits,
  output logic          drop,
  input  logic          clr_drop
);

  localparam int BW = $clog2(WIN_LEN);
  localparam logic [BW-1:0] LAST = BW'(WIN_LEN - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nx;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] win_nx;
  logic [CW-1:0] win_inc;
  logic [CW-1:0] load_cnt;
  logic          load;
  logic          load_part;
  logic          drop_ev;

  assign win_inc = (det && win_cnt != CMAX)
                 ? win_cnt + CW'(1) : win_cnt;

  // A report that arrives while the old one is still held is discarded.
  assign drop_ev = load && rpt_valid && !rpt_ready;

  // Window sequencing: open, accumulate, close full or cut short.
  always_comb begin
    state_nx  = state;
    bit_nx    = bit_cnt;
    win_nx    = win_cnt;
    load      = 1'b0;
    load_part = 1'b0;
    load_cnt  = win_cnt;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = ACTIVE;
          bit_nx   = BW'(1);
          win_nx   = CW'(det);
        end
      end
      ACTIVE: begin
        if (!en) begin
          load      = 1'b1;
          load_part = 1'b1;
          load_cnt  = win_cnt;
          state_nx  = IDLE;
          bit_nx    = '0;
          win_nx    = '0;
        end else if (bit_cnt == LAST) begin
          load     = 1'b1;
          load_cnt = win_inc;
          state_nx = IDLE;
          bit_nx   = '0;
          win_nx   = '0;
        end else begin
          bit_nx = bit_cnt + BW'(1);
          win_nx = win_inc;
        end
      end
      default: ;
    endcase
  end

  // Window state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      win_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      win_cnt <= win_nx;
    end
  end

  // One-entry report buffer; a load beats a same-cycle pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_valid   <= 1'b0;
      rpt_count   <= '0;
      rpt_partial <= 1'b0;
    end else if (load && !drop_ev) begin
      rpt_valid   <= 1'b1;
      rpt_count   <= load_cnt;
      rpt_partial <= load_part;
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop outranks a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (drop_ev) begin
      drop <= 1'b1;
    end else if (clr_drop) begin
      drop <= 1'b0;
    end
  end

  // Saturating lifetime hit total over counted cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_hits <= '0;
    end else if (en && det && total_hits != 16'hFFFF) begin
      total_hits <= total_hits + 16'd1;
    end
  end

endmodule

// File: tb/tb_match_window_counter.sv
// tb_match_window_counter: directed stimulus with a report scoreboard,
// plus a narrow-count instance for saturation.
module tb_match_window_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        det = 1'b0;
  logic        rpt_ready = 1'b0;
  logic        clr_drop = 1'b0;
  logic        rpt_valid;
  logic [7:0]  rpt_count;
  logic        rpt_partial;
  logic [15:0] total_hits;
  logic        drop;
  logic        v2;
  logic [1:0]  c2;
  logic        p2;
  logic [15:0] t2;
  logic        d2;

  typedef struct {
    logic [7:0] c;
    logic       p;
  } rep_t;

  rep_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_tot = '0;

  match_window_counter #(.WIN_LEN(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .det(det),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_count(rpt_count), .rpt_partial(rpt_partial),
    .total_hits(total_hits), .drop(drop), .clr_drop(clr_drop)
  );

  match_window_counter #(.WIN_LEN(16), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .det(det),
    .rpt_valid(v2), .rpt_ready(rpt_ready),
    .rpt_count(c2), .rpt_partial(p2),
    .total_hits(t2), .drop(d2), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic d);
    en  = e;
    det = d;
    @(posedge clk);
    #1;
    if (e && d && exp_tot != 16'hFFFF) exp_tot++;
  endtask

  task automatic window(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) tick(1'b1, mask[i]);
  endtask

  task automatic expect_rpt(input string tag);
    rep_t r;
    chk({tag, "_valid"}, rpt_valid, 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "_count"}, rpt_count, r.c);
      chk({tag, "_partial"}, rpt_partial, r.p);
    end
  endtask

  task automatic pop(input string tag);
    rpt_ready = 1'b1;
    tick(1'b0, 1'b0);
    rpt_ready = 1'b0;
    chk({tag, "_popped"}, rpt_valid, 0);
  endtask

  initial begin
    // reset values
    #3;
    chk("rst_valid", rpt_valid, 0);
    chk("rst_count", rpt_count, 0);
    chk("rst_partial", rpt_partial, 0);
    chk("rst_total", total_hits, 0);
    chk("rst_drop", drop, 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // full window, hits on cycles 4, 8, 12
    for (int i = 1; i <= 15; i++) tick(1'b1, (i % 4) == 0);
    chk("w1_early", rpt_valid, 0);
    tick(1'b1, 1'b0);
    sb.push_back('{8'd3, 1'b0});
    expect_rpt("w1");
    chk("w1_total", total_hits, exp_tot);
    pop("w1");

    // partial window cut by en falling, det on the cut cycle ignored
    for (int i = 1; i <= 6; i++) tick(1'b1, i == 4);
    tick(1'b0, 1'b1);
    sb.push_back('{8'd1, 1'b1});
    expect_rpt("part");
    chk("part_total", total_hits, exp_tot);
    chk("part_drop", drop, 0);
    pop("part");

    // back-to-back windows with no consumer: second report dropped
    window(16'h0001);
    sb.push_back('{8'd1, 1'b0});
    window(16'h0021);
    expect_rpt("ovf");
    chk("ovf_drop", drop, 1);
    clr_drop = 1'b1;
    tick(1'b0, 1'b0);
    clr_drop = 1'b0;
    chk("clr_drop", drop, 0);
    chk("clr_keep_valid", rpt_valid, 1);
    chk("clr_keep_count", rpt_count, 1);
    pop("ovf");

    // drop event in the same cycle as clr_drop keeps drop set
    window(16'h0000);
    sb.push_back('{8'd0, 1'b0});
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1);
    clr_drop = 1'b1;
    tick(1'b1, 1'b1);
    clr_drop = 1'b0;
    chk("clr_vs_drop", drop, 1);
    expect_rpt("held");
    pop("held");
    clr_drop = 1'b1;
    tick(1'b0, 1'b0);
    clr_drop = 1'b0;
    chk("clr2_drop", drop, 0);

    // window close coincident with pop of the previous report
    window(16'h0100);
    sb.push_back('{8'd1, 1'b0});
    expect_rpt("co_a");
    for (int i = 0; i < 15; i++) tick(1'b1, i == 2 || i == 9);
    chk("co_hold", rpt_valid, 1);
    rpt_ready = 1'b1;
    tick(1'b1, 1'b0);
    rpt_ready = 1'b0;
    sb.push_back('{8'd2, 1'b0});
    expect_rpt("co_b");
    chk("co_drop", drop, 0);
    chk("co_total", total_hits, exp_tot);
    pop("co_b");

    // asynchronous reset mid-window with a report held
    window(16'h0004);
    sb.push_back('{8'd1, 1'b0});
    expect_rpt("pre_rst");
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", rpt_valid, 0);
    chk("mrst_count", rpt_count, 0);
    chk("mrst_partial", rpt_partial, 0);
    chk("mrst_total", total_hits, 0);
    chk("mrst_drop", drop, 0);
    sb.delete();
    exp_tot = '0;
    en = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) tick(1'b1, i == 0);
    chk("post_early", rpt_valid, 0);
    tick(1'b1, 1'b1);
    sb.push_back('{8'd2, 1'b0});
    expect_rpt("post");
    chk("post_total", total_hits, exp_tot);

    // saturation of a 2-bit window count
    en = 1'b0;
    rst = 1'b0;
    #4 rst = 1'b1;
    exp_tot = '0;
    window(16'hFFFF);
    sb.push_back('{8'd16, 1'b0});
    expect_rpt("sat8");
    chk("sat_valid", v2, 1);
    chk("sat_count", c2, 3);
    chk("sat_partial", p2, 0);
    chk("sat_total", t2, exp_tot);
    chk("sat_total8", total_hits, exp_tot);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Sits directly downstream of the serial 1010 Mealy sequence detector; consumes its single-cycle match pulse.
- Counts matches over fixed windows of WIN_LEN bit-times.
- Hands each window's count to software/logging logic through a one-entry valid/ready report buffer.
- Keeps a saturating lifetime hit total and a sticky drop flag.

Parameters:
- WIN_LEN, 16, bit-times per window; legal range 2..65535.
- CW, 8, width of the per-window count; saturates at 2^CW-1.

Ports:
- clk  input  1  rising-edge clock, same clock as the detector.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  counting enable; a cycle with en=1 is a counted bit-time.
- det  input  1  match pulse from the detector's out, sampled every clk.
- rpt_valid  output  1  report buffer holds a report.
- rpt_ready  input  1  consumer accepts the report.
- rpt_count  output  CW  match count of the reported window.
- rpt_partial  output  1  report is from a window cut short by en falling.
- total_hits  output  16  saturating count of det over all counted cycles.
- drop  output  1  sticky: a report was lost because the buffer was full.
- clr_drop  input  1  clears drop.

Behaviour:
Reset (rst=0, asynchronous):
- FSM to IDLE.
- bit_cnt=0, win_cnt=0.
- rpt_valid=0, rpt_count=0, rpt_partial=0, total_hits=0, drop=0.

FSM states are IDLE (no window open, bit_cnt=0) and ACTIVE (window open).
- IDLE, en=1: counted cycle; go to ACTIVE with bit_cnt=1, win_cnt=det.
- IDLE, en=0: stay in IDLE; det ignored.
- ACTIVE, en=1, bit_cnt<WIN_LEN-1: bit_cnt+=1, win_cnt+=det.
- ACTIVE, en=1, bit_cnt==WIN_LEN-1: window closes.
  - Load report = win_cnt+det (saturated), rpt_partial=0.
  - Clear bit_cnt and win_cnt; go to IDLE.
  - A following en=1 cycle opens the next window with no gap cycle.
- ACTIVE, en=0: det in this cycle is ignored.
  - Load partial report = win_cnt, rpt_partial=1.
  - Clear counters; go to IDLE.

Arithmetic:
- win_cnt and the loaded count saturate at 2^CW-1; no wrap.
- total_hits increments on det=1 in counted cycles only; saturates at 16'hFFFF.

Report buffer (one entry, registered):
- Load is visible at rpt_valid one cycle after the closing edge.
- rpt_valid holds until the cycle where rpt_valid&&rpt_ready; rpt_count and rpt_partial are stable while held.
- Pop and load in the same cycle: the load wins; rpt_valid stays 1 with the new data.
- Load while full with no pop: the new report is discarded, the old one is kept, and drop is set.
- clr_drop=1 clears drop next cycle. A simultaneous new drop event wins: drop stays 1.
- rpt_ready is ignored while rpt_valid=0.

Combinational paths:
- No combinational path from any input to any output.

Test Plan:
- Defaults; en=1 for 16 cycles with det=1 on cycles 4, 8, 12 -> rpt_valid=1 after cycle 16, rpt_count=3, rpt_partial=0; with rpt_ready=1, rpt_valid drops the next cycle; total_hits=3.
- en=1 for 6 cycles with det=1 on cycle 4; en=0 on cycle 7 with det=1 -> rpt_count=1, rpt_partial=1; total_hits=1 (cycle-7 det is ignored).
- rpt_ready=0; run 2 full windows of 1 and 2 hits -> rpt_count stays 1, drop=1; clr_drop pulse -> drop=0; rpt_valid stays 1.
- CW=2; 16 counted cycles with det=1 every cycle -> rpt_count=3 (saturated); total_hits=16.
- Window close coincident with a pop of the previous report -> no drop; rpt_valid is continuous and rpt_count updates to the new value.
- Assert rst low mid-window with rpt_valid=1 -> all outputs 0 immediately; the first window after release counts from bit 1.
